hi_xcorr_ssp_tx: RTL and testbench

Serializer stage downstream of the HF reader cross-correlator. It accepts one 16-bit report per strobe: an 8-bit signed I correlation and an 8-bit signed Q correlation. Reports are buffered in a 2-entry FIFO and shifted out to the ARM as SPI-master frames, with `ssp_frame` as an active-low enable. Everything runs on the 13.56 MHz carrier clock. The block replaces ad-hoc serialization in the correlator with a clean, gapped, overflow-reporting transmitter.

---
 rtl/hi_xcorr_ssp_tx.sv | 142 ++++++++++++++
 tb/tb_hi_xcorr_ssp_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hi_xcorr_ssp_tx.sv
// Correlator report serializer: 2-deep FIFO of {I,Q} words shifted out MSB-first
// as gapped SPI-master frames with an active-low frame enable and sticky overflow.
module hi_xcorr_ssp_tx #(
  parameter int unsigned HALF_PERIOD = 1,
  parameter int unsigned FRAME_GAP   = 2
) (
  input  logic       ck_1356meg,
  input  logic       rst_n,
  input  logic [7:0] corr_i,
  input  logic [7:0] corr_q,
  input  logic       corr_valid,
  input  logic       clr_overflow,
  output logic       ssp_clk,
  output logic       ssp_din,
  output logic       ssp_frame,
  output logic       busy,
  output logic       overflow
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  localparam int CW = 4;

  state_t        state, state_nx;
  logic [15:0]   mem [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    count;
  logic [CW-1:0] div_cnt, gap_cnt;
  logic [3:0]    bit_cnt;
  logic [14:0]   shreg;
  logic          load, push_ok, drop;
  logic          fifo_empty, fifo_full, div_wrap, gap_done, last_fall;

  assign fifo_empty = (count == 2'd0);
  assign fifo_full  = (count == 2'd2);
  assign div_wrap   = (div_cnt == CW'(HALF_PERIOD - 1));
  assign gap_done   = (gap_cnt == CW'(FRAME_GAP - 1));
  // Falling ssp_clk with no bits left ends the frame.
  assign last_fall  = div_wrap && ssp_clk && (bit_cnt == '0);
  assign push_ok    = corr_valid && (!fifo_full || load);
  assign drop       = corr_valid && fifo_full && !load;
  assign busy       = !fifo_empty || (state != S_IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_nx = S_SHIFT;
          load     = 1'b1;
        end
      end
      S_SHIFT: begin
        if (last_fall) state_nx = S_GAP;
      end
      S_GAP: begin
        if (gap_done) begin
          if (!fifo_empty) begin
            state_nx = S_SHIFT;
            load     = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (load)    rd_ptr <= ~rd_ptr;
      case ({push_ok, load})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers and count make stale entries unreachable.
  always_ff @(posedge ck_1356meg) begin
    if (push_ok) mem[wr_ptr] <= {corr_i, corr_q};
  end

  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ssp_clk   <= 1'b0;
      ssp_din   <= 1'b0;
      ssp_frame <= 1'b1;
      shreg     <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nx;
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;

      if (load) begin
        shreg     <= mem[rd_ptr][14:0];
        ssp_din   <= mem[rd_ptr][15];
        ssp_frame <= 1'b0;
        ssp_clk   <= 1'b0;
        bit_cnt   <= 4'd15;
        div_cnt   <= '0;
      end else if (state == S_SHIFT) begin
        if (div_wrap) begin
          div_cnt <= '0;
          ssp_clk <= ~ssp_clk;
          // Data advances only on the falling ssp_clk edge.
          if (ssp_clk) begin
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 4'd1;
              ssp_din <= shreg[14];
              shreg   <= {shreg[13:0], 1'b0};
            end else begin
              ssp_frame <= 1'b1;
              ssp_din   <= 1'b0;
              gap_cnt   <= '0;
            end
          end
        end else begin
          div_cnt <= div_cnt + CW'(1);
        end
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hi_xcorr_ssp_tx.sv
// Directed bench: expected words queued at push time, a negedge monitor
// reassembles each frame and compares it with the queue head.
module tb_hi_xcorr_ssp_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] corr_i, corr_q;
  logic       valid1, valid3, clr_overflow;
  logic       sclk1, din1, frame1, busy1, ovf1;
  logic       sclk3, din3, frame3, busy3, ovf3;
  logic       sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hi_xcorr_ssp_tx #(.HALF_PERIOD(1), .FRAME_GAP(2)) dut1 (
    .ck_1356meg(clk), .rst_n(rst_n), .corr_i(corr_i), .corr_q(corr_q),
    .corr_valid(valid1), .clr_overflow(clr_overflow),
    .ssp_clk(sclk1), .ssp_din(din1), .ssp_frame(frame1), .busy(busy1), .overflow(ovf1));

  hi_xcorr_ssp_tx #(.HALF_PERIOD(3), .FRAME_GAP(2)) dut3 (
    .ck_1356meg(clk), .rst_n(rst_n), .corr_i(corr_i), .corr_q(corr_q),
    .corr_valid(valid3), .clr_overflow(clr_overflow),
    .ssp_clk(sclk3), .ssp_din(din3), .ssp_frame(frame3), .busy(busy3), .overflow(ovf3));

  // Observed instance is chosen by sel; only one is ever active at a time.
  logic m_clk, m_din, m_frame, m_busy, m_ovf;
  assign m_clk   = sel ? sclk3  : sclk1;
  assign m_din   = sel ? din3   : din1;
  assign m_frame = sel ? frame3 : frame1;
  assign m_busy  = sel ? busy3  : busy1;
  assign m_ovf   = sel ? ovf3   : ovf1;

  logic [15:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor state
  logic        in_frame = 1'b0;
  logic        lvl;
  logic        run_bad;
  logic [15:0] word;
  logic [15:0] exp_w;
  int          run, rises, low_cnt, high_cnt = 0, last_gap = 0, frame_cnt = 0, h;

  always @(negedge clk) begin
    h = sel ? 3 : 1;
    if (!rst_n) begin
      in_frame = 1'b0;
      high_cnt = 0;
    end else if (!m_frame) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        last_gap = high_cnt;
        high_cnt = 0;
        low_cnt  = 0;
        rises    = 0;
        word     = '0;
        run      = 0;
        lvl      = 1'b0;
        run_bad  = 1'b0;
      end
      low_cnt++;
      if (m_clk == lvl) begin
        run++;
      end else begin
        if (run != h) run_bad = 1'b1;
        run = 1;
        lvl = m_clk;
        if (m_clk) begin
          rises++;
          word = {word[14:0], m_din};
        end
      end
    end else begin
      if (in_frame) begin
        in_frame = 1'b0;
        if (run != h) run_bad = 1'b1;
        frame_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_frame", {16'h0, word}, 32'hFFFF_FFFF);
        end else begin
          exp_w = sb_q.pop_front();
          check("frame_data", {16'h0, word}, {16'h0, exp_w});
        end
        check("rise_count", rises, 16);
        check("frame_low_cycles", low_cnt, 32 * h);
        check("clk_half_period", {31'h0, run_bad}, 0);
      end
      high_cnt++;
    end
  end

  // Drives one push at the next edge; acc says whether the word should be kept.
  task automatic push(input logic [7:0] i, input logic [7:0] q, input logic acc, input logic clr);
    corr_i       = i;
    corr_q       = q;
    valid1       = !sel;
    valid3       = sel;
    clr_overflow = clr;
    if (acc) sb_q.push_back({i, q});
    @(posedge clk);
    #1;
    valid1       = 1'b0;
    valid3       = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic clear_ovf();
    clr_overflow = 1'b1;
    @(posedge clk);
    #1;
    clr_overflow = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_busy && n < 600);
    check(name, {31'h0, m_busy}, 0);
    @(posedge clk);
    #1;
  endtask

  int f0;

  initial begin
    rst_n = 1'b0; sel = 1'b0;
    corr_i = '0; corr_q = '0; valid1 = 1'b0; valid3 = 1'b0; clr_overflow = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_frame", {31'h0, frame1}, 1);
    check("rst_clk",   {31'h0, sclk1},  0);
    check("rst_din",   {31'h0, din1},   0);
    check("rst_busy",  {31'h0, busy1},  0);
    check("rst_ovf",   {31'h0, ovf1},   0);
    check("rst_frame3", {31'h0, frame3}, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single word at defaults
    f0 = frame_cnt;
    push(8'hA5, 8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    check("single_busy_rise", {31'h0, busy1}, 1);
    @(negedge clk);
    check("single_frame_fall", {31'h0, frame1}, 0);
    repeat (35) @(negedge clk);
    check("single_busy_done", {31'h0, busy1}, 0);
    check("single_frames", frame_cnt - f0, 1);
    @(posedge clk);
    #1;

    // Back-to-back
    f0 = frame_cnt;
    push(8'h01, 8'h02, 1'b1, 1'b0);
    push(8'h80, 8'h01, 1'b1, 1'b0);
    wait_idle("b2b_idle");
    check("b2b_frames", frame_cnt - f0, 2);
    check("b2b_gap", last_gap, 2);
    check("b2b_ovf", {31'h0, ovf1}, 0);

    // Overflow: third word fits because the first was popped, fourth is dropped
    f0 = frame_cnt;
    push(8'h11, 8'h22, 1'b1, 1'b0);
    push(8'h33, 8'h44, 1'b1, 1'b0);
    push(8'h55, 8'h66, 1'b1, 1'b0);
    push(8'h77, 8'h88, 1'b0, 1'b0);
    @(negedge clk);
    check("ovf_set", {31'h0, ovf1}, 1);
    @(posedge clk);
    #1;
    clear_ovf();
    @(negedge clk);
    check("ovf_clear", {31'h0, ovf1}, 0);
    @(posedge clk);
    #1;
    wait_idle("ovf_idle");
    check("ovf_frames", frame_cnt - f0, 3);

    // Set wins over clear in the same cycle
    push(8'h9A, 8'hBC, 1'b1, 1'b0);
    push(8'hDE, 8'hF0, 1'b1, 1'b0);
    push(8'h0F, 8'hE1, 1'b1, 1'b0);
    push(8'hCC, 8'hDD, 1'b0, 1'b1);
    @(negedge clk);
    check("collision_ovf", {31'h0, ovf1}, 1);
    @(posedge clk);
    #1;
    clear_ovf();
    wait_idle("collision_idle");
    check("collision_ovf_cleared", {31'h0, ovf1}, 0);

    // HALF_PERIOD = 3 instance
    sel = 1'b1;
    f0 = frame_cnt;
    push(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_idle("h3_idle");
    check("h3_frames", frame_cnt - f0, 1);
    sel = 1'b0;

    // Reset during bit 7, then a clean frame
    push(8'hBE, 8'hEF, 1'b1, 1'b0);
    repeat (14) @(posedge clk);
    #1 rst_n = 1'b0;
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_frame", {31'h0, frame1}, 1);
    check("midrst_clk",   {31'h0, sclk1},  0);
    check("midrst_din",   {31'h0, din1},   0);
    check("midrst_busy",  {31'h0, busy1},  0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    f0 = frame_cnt;
    push(8'h12, 8'h34, 1'b1, 1'b0);
    wait_idle("postrst_idle");
    check("postrst_frames", frame_cnt - f0, 1);

    check("queue_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
